// File: rtl/turn_phase_seq.sv
// Turn-phase sequencer: walks START/ACTION/BUY/DRAW for each player and keeps
// the per-turn action and buy budgets; mode is the FSM state register itself.
module turn_phase_seq #(
  parameter int NUM_PLAYERS   = 2,
  parameter int START_ACTIONS = 1,
  parameter int START_BUYS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e,
  input  logic       but_sel,
  input  logic       but_end,
  input  logic       action_played,
  input  logic [2:0] plus_actions,
  input  logic [2:0] plus_buys,
  input  logic       buy_done,
  input  logic       draw_done,
  input  logic       game_over,
  output logic [2:0] mode,
  output logic [3:0] actions_left,
  output logic [3:0] buys_left,
  output logic [1:0] player,
  output logic [7:0] turn_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    ACTION    = 3'd2,
    ACTIONEND = 3'd3,
    BUY       = 3'd4,
    DRAW      = 3'd5,
    ENDGAME   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] act_q, act_d;
  logic [3:0] buys_q, buys_d;
  logic [1:0] player_q, player_d;
  logic [7:0] turn_q, turn_d;

  logic [4:0] act_sum, act_dec, buy_sum;
  logic [3:0] act_new, buys_new, buys_dec;

  // Inputs are single-cycle pulses sampled on each enabled edge; there is no
  // handshake back to the sender, so a pulse seen while e=0 is simply dropped.
  always_comb begin
    act_sum  = {1'b0, act_q} + {2'b00, plus_actions};
    act_dec  = (act_sum == 5'd0) ? 5'd0 : act_sum - 5'd1;
    act_new  = (act_dec > 5'd15) ? 4'd15 : act_dec[3:0];
    buy_sum  = {1'b0, buys_q} + {2'b00, plus_buys};
    buys_new = (buy_sum > 5'd15) ? 4'd15 : buy_sum[3:0];
    buys_dec = (buys_q == 4'd0) ? 4'd0 : buys_q - 4'd1;

    state_d  = state_q;
    act_d    = act_q;
    buys_d   = buys_q;
    player_d = player_q;
    turn_d   = turn_q;

    if (e) begin
      case (state_q)
        IDLE: state_d = START;
        START: begin
          act_d  = 4'(START_ACTIONS);
          buys_d = 4'(START_BUYS);
          if (but_sel) state_d = ACTION;
        end
        ACTION: begin
          if (action_played) begin
            act_d  = act_new;
            buys_d = buys_new;
          end
          if (but_end || act_d == 4'd0) state_d = ACTIONEND;
        end
        ACTIONEND: begin
          act_d   = 4'd0;
          state_d = BUY;
        end
        BUY: begin
          if (buy_done) buys_d = buys_dec;
          if (but_end || buys_d == 4'd0) state_d = DRAW;
        end
        DRAW: begin
          buys_d = 4'd0;
          if (draw_done) begin
            if (game_over) begin
              state_d = ENDGAME;
            end else begin
              state_d  = START;
              turn_d   = turn_q + 8'd1;
              player_d = (player_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : player_q + 2'd1;
            end
          end
        end
        ENDGAME: state_d = ENDGAME;
        default: state_d = IDLE;
      endcase
    end else if (state_q > ENDGAME) begin
      // The unused encoding recovers even while disabled.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      act_q    <= 4'd0;
      buys_q   <= 4'd0;
      player_q <= 2'd0;
      turn_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      buys_q   <= buys_d;
      player_q <= player_d;
      turn_q   <= turn_d;
    end
  end

  assign mode         = state_q;
  assign actions_left = act_q;
  assign buys_left    = buys_q;
  assign player       = player_q;
  assign turn_count   = turn_q;

endmodule

// File: tb/tb_turn_phase_seq.sv
// Directed bench for turn_phase_seq: the driver pushes the expected register
// snapshot per edge and a monitor pops and compares it after that edge.
module tb_turn_phase_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       e = 1'b1;
  logic       but_sel = 1'b0, but_end = 1'b0, action_played = 1'b0;
  logic [2:0] plus_actions = 3'd0, plus_buys = 3'd0;
  logic       buy_done = 1'b0, draw_done = 1'b0, game_over = 1'b0;
  logic [2:0] mode;
  logic [3:0] actions_left, buys_left;
  logic [1:0] player;
  logic [7:0] turn_count;

  logic [20:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  turn_phase_seq #(.NUM_PLAYERS(2), .START_ACTIONS(1), .START_BUYS(1)) dut (
    .clk(clk), .reset(reset), .e(e), .but_sel(but_sel), .but_end(but_end),
    .action_played(action_played), .plus_actions(plus_actions),
    .plus_buys(plus_buys), .buy_done(buy_done), .draw_done(draw_done),
    .game_over(game_over), .mode(mode), .actions_left(actions_left),
    .buys_left(buys_left), .player(player), .turn_count(turn_count)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [20:0] observed();
    return {mode, actions_left, buys_left, player, turn_count};
  endfunction

  function automatic void compare(input string name, input logic [20:0] act,
                                  input logic [20:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got mode=%0d act=%0d buys=%0d player=%0d turn=%0d, want mode=%0d act=%0d buys=%0d player=%0d turn=%0d",
                  name, act[20:18], act[17:14], act[13:10], act[9:8], act[7:0],
                  req[20:18], req[17:14], req[13:10], req[9:8], req[7:0]);
  endfunction

  // Drive one enabled/disabled edge worth of inputs and queue the expected result.
  task automatic step(input logic en, input logic sel, input logic bend,
                      input logic ap, input logic [2:0] pa, input logic [2:0] pb,
                      input logic bd, input logic dd, input logic go,
                      input logic [2:0] x_mode, input logic [3:0] x_act,
                      input logic [3:0] x_buys, input logic [1:0] x_player,
                      input logic [7:0] x_turn, input string name);
    @(negedge clk);
    e = en; but_sel = sel; but_end = bend; action_played = ap;
    plus_actions = pa; plus_buys = pb; buy_done = bd; draw_done = dd;
    game_over = go;
    exp_q.push_back({x_mode, x_act, x_buys, x_player, x_turn});
    name_q.push_back(name);
    @(posedge clk);
  endtask

  // Monitor: samples 2 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) compare(name_q.pop_front(), observed(), exp_q.pop_front());
    end
  end

  initial begin
    #12;
    compare("reset_state", observed(), 21'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    //   en sel end ap pa pb bd dd go   mode act buys pl turn
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    1,  0,  0,  0, 0, "idle_to_start");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    1,  1,  1,  0, 0, "start_load");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0,    1,  1,  1,  0, 0, "enable_gate");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0,    2,  1,  1,  0, 0, "sel_to_action");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0,    3,  1,  1,  0, 0, "end_action");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    4,  0,  1,  0, 0, "actionend_to_buy");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0,    5,  0,  0,  0, 0, "last_buy_to_draw");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0,    1,  0,  0,  1, 1, "draw_to_start");

    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    1,  1,  1,  1, 1, "start_load2");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0,    2,  1,  1,  1, 1, "sel2");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0,    2,  1,  1,  1, 1, "buy_done_ignored");
    step(1, 0, 0, 1, 2, 1, 0, 0, 0,    2,  2,  2,  1, 1, "chain_plus");
    step(1, 0, 0, 1, 0, 0, 0, 0, 0,    2,  1,  2,  1, 1, "chain_play");
    step(1, 0, 0, 1, 0, 0, 0, 0, 0,    3,  0,  2,  1, 1, "chain_exhaust");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    4,  0,  2,  1, 1, "buy2");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0,    4,  0,  1,  1, 1, "buy_dec");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0,    5,  0,  0,  1, 1, "buy_dec_zero");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0,    1,  0,  0,  0, 2, "player_wrap");

    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    1,  1,  1,  0, 2, "start_load3");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0,    2,  1,  1,  0, 2, "sel3");
    step(1, 0, 0, 1, 7, 7, 0, 0, 0,    2,  7,  8,  0, 2, "plus7_a");
    step(1, 0, 0, 1, 7, 7, 0, 0, 0,    2, 13, 15,  0, 2, "plus7_b");
    step(1, 0, 0, 1, 7, 7, 0, 0, 0,    2, 15, 15,  0, 2, "sat_a");
    step(1, 0, 0, 1, 7, 0, 0, 0, 0,    2, 15, 15,  0, 2, "sat_b");
    step(1, 0, 1, 1, 0, 1, 0, 0, 0,    3, 14, 15,  0, 2, "play_and_end");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    4,  0, 15,  0, 2, "actionend_clear");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0,    5,  0, 15,  0, 2, "buy_end");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0,    5,  0,  0,  0, 2, "draw_clear_buys");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1,    6,  0,  0,  0, 2, "endgame");
    step(1, 1, 1, 1, 3, 3, 1, 1, 0,    6,  0,  0,  0, 2, "endgame_absorb");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1,    6,  0,  0,  0, 2, "endgame_hold");

    @(negedge clk);
    e = 1'b0; but_sel = 1'b0; but_end = 1'b0; action_played = 1'b0;
    buy_done = 1'b0; draw_done = 1'b0; game_over = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1 compare("async_reset", observed(), 21'd0);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drained: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
